seg_mux_scheduler: RTL and testbench

- Time-multiplexing controller that shares one hex-to-seven-segment decoder and segment bus between NUM_DIGITS common-anode digits.
- Steps through the enabled digits on a fixed schedule. Inserts a blanking interval (all anodes off) before each digit's dwell to prevent ghosting.
- Double-buffers the digit values so that a keypad-driven update applies atomically at a frame boundary.
- Sits between the digit-history registers fed by the key decoder and the shared segment decoder. Runs on the slow system clock.

---
 rtl/seg_mux_scheduler.sv | 174 +++++++++++++++++
 tb/tb_seg_mux_scheduler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_mux_scheduler.sv
// Time-multiplexed seven-segment scan controller.
// Scans the enabled digits in ascending index order. Each digit gets a blanking
// interval with all anodes off, then a dwell with only its own anode on.
// Digit values are double-buffered: a load goes to a pending buffer, which is
// copied to the displayed buffer only at a frame wrap.
module seg_mux_scheduler #(
  parameter int unsigned NUM_DIGITS       = 2,
  parameter int unsigned DWELL_CYCLES     = 12000,
  parameter int unsigned BLANK_CYCLES     = 200,
  parameter bit          ANODE_ACTIVE_LOW = 1'b1,
  localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1,
  localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES,
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [3:0]              hex_out,
  output logic [NUM_DIGITS-1:0]   anodes,
  output logic [IDX_W-1:0]        cur_digit,
  output logic                    frame_done
);

  typedef enum logic [1:0] {StNone, StBlank, StDwell} state_e;

  localparam logic [CNT_W-1:0]      BlankLast  = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]      DwellLast  = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [NUM_DIGITS-1:0] AnodesOff  = ANODE_ACTIVE_LOW ? '1 : '0;

  state_e                  r_state, w_state_d;
  logic [IDX_W-1:0]        r_idx, w_idx_d;
  logic [CNT_W-1:0]        r_cnt, w_cnt_d;
  logic [4*NUM_DIGITS-1:0] r_active, w_active_d;
  logic [4*NUM_DIGITS-1:0] r_pending, w_pending_d;
  logic                    r_pend_valid, w_pend_valid_d;
  logic [3:0]              r_hex, w_hex_d;
  logic [NUM_DIGITS-1:0]   r_anodes, w_anodes_d;
  logic                    r_frame_done;

  logic                    w_any_en;
  logic [IDX_W-1:0]        w_adv_idx;
  logic                    w_adv_hit;
  logic [IDX_W-1:0]        w_low_idx;
  logic                    w_wrap;

  assign w_any_en = |digit_en;

  // Next enabled digit above r_idx (wrapping), and the lowest enabled digit.
  always_comb begin
    w_adv_idx = r_idx;
    w_adv_hit = 1'b0;
    for (int k = 1; k <= int'(NUM_DIGITS); k++) begin
      if (!w_adv_hit && digit_en[IDX_W'((int'(r_idx) + k) % int'(NUM_DIGITS))]) begin
        w_adv_idx = IDX_W'((int'(r_idx) + k) % int'(NUM_DIGITS));
        w_adv_hit = 1'b1;
      end
    end
    w_low_idx = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      if (digit_en[i]) w_low_idx = IDX_W'(i);
    end
  end

  // Scan FSM next state; w_wrap marks the edge that starts a new frame.
  always_comb begin
    w_state_d = r_state;
    w_idx_d   = r_idx;
    w_cnt_d   = r_cnt;
    w_wrap    = 1'b0;
    if (!w_any_en) begin
      w_state_d = StNone;
      w_cnt_d   = '0;
    end else begin
      unique case (r_state)
        StNone: begin
          w_state_d = StBlank;
          w_idx_d   = w_low_idx;
          w_cnt_d   = '0;
          w_wrap    = 1'b1;
        end
        StBlank: begin
          if (!digit_en[r_idx]) begin
            // Current digit vanished: move on and restart the blanking count.
            w_idx_d = w_adv_idx;
            w_cnt_d = '0;
            w_wrap  = (w_adv_idx <= r_idx);
          end else if (r_cnt == BlankLast) begin
            w_state_d = StDwell;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
        StDwell: begin
          if (!digit_en[r_idx] || (r_cnt == DwellLast)) begin
            w_state_d = StBlank;
            w_idx_d   = w_adv_idx;
            w_cnt_d   = '0;
            w_wrap    = (w_adv_idx <= r_idx);
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
        default: begin
          w_state_d = StBlank;
          w_cnt_d   = '0;
        end
      endcase
    end
  end

  // Double buffer: commit at frame wrap; a load on the wrap edge bypasses pending.
  always_comb begin
    w_active_d     = r_active;
    w_pending_d    = r_pending;
    w_pend_valid_d = r_pend_valid;
    if (w_wrap) begin
      if (load) begin
        w_active_d = digits_in;
      end else if (r_pend_valid) begin
        w_active_d = r_pending;
      end
      w_pend_valid_d = 1'b0;
    end else if (load) begin
      w_pending_d    = digits_in;
      w_pend_valid_d = 1'b1;
    end
  end

  // Registered outputs derived from the next state, so they line up with it.
  always_comb begin
    w_hex_d    = '0;
    w_anodes_d = AnodesOff;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (w_idx_d == IDX_W'(i)) begin
        w_hex_d = w_active_d[4*i +: 4];
        if (w_state_d == StDwell) w_anodes_d[i] = ~AnodesOff[i];
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= StBlank;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_active     <= '0;
      r_pending    <= '0;
      r_pend_valid <= 1'b0;
      r_hex        <= '0;
      r_anodes     <= AnodesOff;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_idx        <= w_idx_d;
      r_cnt        <= w_cnt_d;
      r_active     <= w_active_d;
      r_pending    <= w_pending_d;
      r_pend_valid <= w_pend_valid_d;
      r_hex        <= w_hex_d;
      r_anodes     <= w_anodes_d;
      r_frame_done <= w_wrap;
    end
  end

  assign hex_out    = r_hex;
  assign anodes     = r_anodes;
  assign cur_digit  = r_idx;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_mux_scheduler.sv
// Self-checking bench for seg_mux_scheduler: directed scenarios plus random
// stimulus, all compared against a phase/time-remaining reference model.
module tb_seg_mux_scheduler;

  localparam int N = 2;
  localparam int D = 4;
  localparam int B = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] digits_in = '0;
  logic       load = 1'b0;
  logic [1:0] digit_en = 2'b11;
  logic [3:0] hex_out;
  logic [1:0] anodes;
  logic [0:0] cur_digit;
  logic       frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  seg_mux_scheduler #(
    .NUM_DIGITS      (N),
    .DWELL_CYCLES    (D),
    .BLANK_CYCLES    (B),
    .ANODE_ACTIVE_LOW(1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .digits_in (digits_in),
    .load      (load),
    .digit_en  (digit_en),
    .hex_out   (hex_out),
    .anodes    (anodes),
    .cur_digit (cur_digit),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 = no digit shown, 1 = blanking, 2 = dwelling.
  int         m_mode;
  int         m_idx;
  int         m_left;
  logic [7:0] m_act;
  logic [7:0] m_pend;
  bit         m_pv;
  bit         m_fd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic bit is_en(input logic [1:0] en, input int i);
    return ((en >> i) & 2'b01) != 2'b00;
  endfunction

  function automatic int next_en(input logic [1:0] en, input int idx);
    for (int k = 1; k <= N; k++) begin
      if (is_en(en, (idx + k) % N)) return (idx + k) % N;
    end
    return idx;
  endfunction

  task automatic model_reset();
    m_mode = 1; m_idx = 0; m_left = B;
    m_act = '0; m_pend = '0; m_pv = 0; m_fd = 0;
  endtask

  task automatic model_step(input logic [1:0] en, input bit ld, input logic [7:0] din);
    bit wrap = 0;
    int n;
    if (en == 2'b00) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_left = B; wrap = 1;
      m_idx = is_en(en, 0) ? 0 : 1;
    end else if (!is_en(en, m_idx) || (m_mode == 2 && m_left == 1)) begin
      n = next_en(en, m_idx);
      wrap = (n <= m_idx);
      m_idx = n; m_mode = 1; m_left = B;
    end else if (m_left == 1) begin
      m_mode = 2; m_left = D;
    end else begin
      m_left--;
    end
    if (wrap) begin
      if (ld) m_act = din;
      else if (m_pv) m_act = m_pend;
      m_pv = 0;
    end else if (ld) begin
      m_pend = din; m_pv = 1;
    end
    m_fd = wrap;
  endtask

  task automatic compare_all();
    logic [1:0] exp_an;
    exp_an = (m_mode == 2) ? (2'b11 & ~(2'b01 << m_idx)) : 2'b11;
    check_eq("anodes", 32'(anodes), 32'(exp_an));
    check_eq("hex_out", 32'(hex_out), 32'(m_act[4*m_idx +: 4]));
    check_eq("cur_digit", 32'(cur_digit), 32'(m_idx));
    check_eq("frame_done", 32'(frame_done), 32'(m_fd));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(digit_en, load, digits_in);
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int         fd_cnt;
  int         guard;
  logic [1:0] an_tab [13];

  initial begin
    an_tab = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b11,
               2'b01, 2'b01, 2'b01, 2'b01, 2'b11};
    repeat (2) @(negedge clk);
    check_eq("reset_anodes", 32'(anodes), 32'h3);
    check_eq("reset_hex", 32'(hex_out), 32'h0);
    reset = 1'b0;
    model_reset();
    cyc = 0;
    compare_all();

    // Basic frame: load at cycle 0 commits only at the first wrap (cycle 12).
    load = 1'b1; digits_in = 8'h16;
    for (int c = 1; c <= 12; c++) begin
      tick();
      load = 1'b0;
      check_eq("basic_anodes", 32'(anodes), 32'(an_tab[c]));
      if (c >= 2 && c <= 5) check_eq("basic_hex_uncommitted", 32'(hex_out), 32'h0);
    end
    check_eq("basic_fd", 32'(frame_done), 32'h1);
    check_eq("basic_hex_commit", 32'(hex_out), 32'h6);

    // Atomic update: load mid-dwell of digit 0, digit 1 keeps the old value.
    ticks(3);
    load = 1'b1; digits_in = 8'h3A;
    tick();
    load = 1'b0;
    ticks(4);
    check_eq("atomic_old_d1", 32'(hex_out), 32'h1);
    check_eq("atomic_an_d1", 32'(anodes), 32'h1);
    ticks(4);
    check_eq("atomic_fd", 32'(frame_done), 32'h1);
    check_eq("atomic_new_d0", 32'(hex_out), 32'hA);
    ticks(8);
    check_eq("atomic_new_d1", 32'(hex_out), 32'h3);

    // Skip and early exit: only digit 0 enabled, drop it mid-dwell, re-enable.
    digit_en = 2'b01;
    tick();
    check_eq("skip_exit_fd", 32'(frame_done), 32'h1);
    fd_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (frame_done === 1'b1) fd_cnt++;
    end
    check_eq("skip_fd_period", 32'(fd_cnt), 32'h2);
    ticks(3);
    check_eq("skip_dwell_an", 32'(anodes), 32'h2);
    digit_en = 2'b00;
    tick();
    check_eq("none_anodes", 32'(anodes), 32'h3);
    ticks(2);
    digit_en = 2'b11;
    tick();
    check_eq("reenable_fd", 32'(frame_done), 32'h1);
    check_eq("reenable_idx", 32'(cur_digit), 32'h0);

    // Load on the exact wrap edge bypasses pending and leaves nothing queued.
    ticks(8);
    load = 1'b1; digits_in = 8'h99;
    tick();
    load = 1'b0;
    ticks(2);
    load = 1'b1; digits_in = 8'h5C;
    tick();
    load = 1'b0;
    check_eq("bypass_fd", 32'(frame_done), 32'h1);
    check_eq("bypass_hex", 32'(hex_out), 32'hC);
    ticks(12);
    check_eq("bypass_no_recommit_fd", 32'(frame_done), 32'h1);
    check_eq("bypass_no_recommit_hex", 32'(hex_out), 32'hC);

    // Async reset asserted between edges in the middle of a dwell.
    guard = 0;
    while (m_mode != 2 && guard < 20) begin
      tick();
      guard++;
    end
    check_eq("reach_dwell", 32'(m_mode), 32'h2);
    #2 reset = 1'b1;
    #1;
    check_eq("async_anodes", 32'(anodes), 32'h3);
    check_eq("async_hex", 32'(hex_out), 32'h0);
    check_eq("async_fd", 32'(frame_done), 32'h0);
    check_eq("async_idx", 32'(cur_digit), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    compare_all();
    ticks(20);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 4) digit_en = 2'($urandom_range(3));
      load = ($urandom_range(99) < 10);
      digits_in = 8'($urandom);
      tick();
    end
    load = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
